// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg: lamp encodings, fault codes and monitor state shared by the
// conflict monitor.                                                 Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

  // Lamp vector bit order is {left, green, yellow, red}
  localparam logic [3:0] LAMP_LEFT   = 4'b1001;
  localparam logic [3:0] LAMP_GREEN  = 4'b0100;
  localparam logic [3:0] LAMP_YELLOW = 4'b0010;
  localparam logic [3:0] LAMP_RED    = 4'b0001;
  localparam logic [3:0] LAMP_DARK   = 4'b0000;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_CONFLICT = 2'b01;
  localparam logic [1:0] FAULT_DARK     = 2'b10;
  localparam logic [1:0] FAULT_INVALID  = 2'b11;

  typedef enum logic [1:0] {
    ST_MONITOR   = 2'd0,
    ST_FLASH_ON  = 2'd1,
    ST_FLASH_OFF = 2'd2
  } mon_state_e;

endpackage : traffic_pkg

`default_nettype wire

// File: rtl/traffic_conflict_monitor_lamp_checker.sv
// ---------------------------------------------------------------------------
// lamp_checker: combinational classification of one lamp vector into
// permissive / dark / invalid.                                      Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lamp_checker
  import traffic_pkg::*;
(
  input  logic [3:0] lamp_i,
  output logic       permissive_o,
  output logic       dark_o,
  output logic       invalid_o
);

  logic w_legal;

  assign w_legal = (lamp_i == LAMP_LEFT)   || (lamp_i == LAMP_GREEN) ||
                   (lamp_i == LAMP_YELLOW) || (lamp_i == LAMP_RED);

  assign permissive_o = |lamp_i[3:1];
  assign dark_o       = (lamp_i == LAMP_DARK);
  assign invalid_o    = !dark_o && !w_legal;

endmodule : lamp_checker

`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor: registered lamp pass-through that latches a fault
// and flashes red on conflict, dark head or illegal pattern.        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int FILTER_CYCLES = 2,
  parameter int FLASH_HALF    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ns_in,
  input  logic [3:0] ew_in,
  input  logic       fault_clr,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int c_filt_w  = $clog2(FILTER_CYCLES + 1);
  localparam int c_flash_w = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [c_filt_w-1:0]  c_filt_max  = c_filt_w'(FILTER_CYCLES);
  localparam logic [c_filt_w-1:0]  c_filt_trip = c_filt_w'(FILTER_CYCLES - 1);
  localparam logic [c_flash_w-1:0] c_flash_end = c_flash_w'(FLASH_HALF - 1);

  logic w_ns_perm, w_ns_dark, w_ns_inv;
  logic w_ew_perm, w_ew_dark, w_ew_inv;

  lamp_checker u_ns_chk (
    .lamp_i       (ns_in),
    .permissive_o (w_ns_perm),
    .dark_o       (w_ns_dark),
    .invalid_o    (w_ns_inv)
  );

  lamp_checker u_ew_chk (
    .lamp_i       (ew_in),
    .permissive_o (w_ew_perm),
    .dark_o       (w_ew_dark),
    .invalid_o    (w_ew_inv)
  );

  logic       w_conflict, w_dark, w_invalid, w_cond;
  logic [1:0] w_code;

  assign w_conflict = w_ns_perm && w_ew_perm;
  assign w_dark     = w_ns_dark || w_ew_dark;
  assign w_invalid  = w_ns_inv || w_ew_inv;
  assign w_cond     = w_conflict || w_dark || w_invalid;
  assign w_code     = w_conflict ? FAULT_CONFLICT :
                      w_dark     ? FAULT_DARK     :
                      w_invalid  ? FAULT_INVALID  : FAULT_NONE;

  mon_state_e             state_q, state_d;
  logic [c_filt_w-1:0]    filt_q, filt_d;
  logic [c_flash_w-1:0]   flash_q, flash_d;
  logic [3:0]             ns_out_q, ns_out_d, ew_out_q, ew_out_d;
  logic                   fault_q, fault_d;
  logic [1:0]             code_q, code_d;

  logic w_trip, w_clr_ok;

  assign w_trip   = (state_q == ST_MONITOR) && w_cond && (filt_q == c_filt_trip);
  assign w_clr_ok = (state_q != ST_MONITOR) && fault_clr && !w_cond;

  // A clean cycle always restarts the filter, which also covers the clear edge
  always_comb begin
    filt_d = '0;
    if (w_cond) begin
      filt_d = (filt_q == c_filt_max) ? filt_q : filt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_MONITOR;
      filt_q   <= '0;
      flash_q  <= '0;
      ns_out_q <= LAMP_RED;
      ew_out_q <= LAMP_RED;
      fault_q  <= 1'b0;
      code_q   <= FAULT_NONE;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      flash_q  <= flash_d;
      ns_out_q <= ns_out_d;
      ew_out_q <= ew_out_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MONITOR: begin
        if (w_trip) state_d = ST_FLASH_ON;
      end
      ST_FLASH_ON: begin
        if (w_clr_ok)                    state_d = ST_MONITOR;
        else if (flash_q == c_flash_end) state_d = ST_FLASH_OFF;
      end
      ST_FLASH_OFF: begin
        if (w_clr_ok)                    state_d = ST_MONITOR;
        else if (flash_q == c_flash_end) state_d = ST_FLASH_ON;
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  // Phase counter restarts on every state change, including the trip edge
  always_comb begin
    flash_d = flash_q + 1'b1;
    if ((state_d != state_q) || (state_q == ST_MONITOR)) begin
      flash_d = '0;
    end
  end

  always_comb begin
    ns_out_d = ns_in;
    ew_out_d = ew_in;
    fault_d  = 1'b0;
    code_d   = FAULT_NONE;
    case (state_q)
      ST_MONITOR: begin
        if (w_trip) begin
          ns_out_d = LAMP_RED;
          ew_out_d = LAMP_RED;
          fault_d  = 1'b1;
          code_d   = w_code;
        end
      end
      ST_FLASH_ON, ST_FLASH_OFF: begin
        if (!w_clr_ok) begin
          ns_out_d = (state_d == ST_FLASH_ON) ? LAMP_RED : LAMP_DARK;
          ew_out_d = (state_d == ST_FLASH_ON) ? LAMP_RED : LAMP_DARK;
          fault_d  = 1'b1;
          code_d   = code_q;
        end
      end
      default: begin
        ns_out_d = LAMP_RED;
        ew_out_d = LAMP_RED;
      end
    endcase
  end

  assign ns_out     = ns_out_q;
  assign ew_out     = ew_out_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule : traffic_conflict_monitor

`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_conflict_monitor: directed vectors with a queued scoreboard
// checking the conflict monitor outputs.                             Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_traffic_conflict_monitor;

  localparam logic [3:0] L   = 4'b1001;
  localparam logic [3:0] G   = 4'b0100;
  localparam logic [3:0] R   = 4'b0001;
  localparam logic [3:0] D   = 4'b0000;
  localparam logic [3:0] BAD = 4'b0110;

  logic       clk;
  logic       rst;
  logic [3:0] ns_in, ew_in;
  logic       fault_clr;
  logic [3:0] ns_out, ew_out;
  logic       fault;
  logic [1:0] fault_code;

  traffic_conflict_monitor #(
    .FILTER_CYCLES (2),
    .FLASH_HALF    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ns_in      (ns_in),
    .ew_in      (ew_in),
    .fault_clr  (fault_clr),
    .ns_out     (ns_out),
    .ew_out     (ew_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned tgt;
    string       name;
    logic [3:0]  ns;
    logic [3:0]  ew;
    logic        f;
    logic [1:0]  c;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Each expectation names the edge after which it must hold
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (mon_e.tgt != cyc || ns_out !== mon_e.ns || ew_out !== mon_e.ew ||
          fault !== mon_e.f || fault_code !== mon_e.c) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got ns=%b ew=%b fault=%b code=%b, want ns=%b ew=%b fault=%b code=%b",
                 mon_e.name, cyc, ns_out, ew_out, fault, fault_code,
                 mon_e.ns, mon_e.ew, mon_e.f, mon_e.c);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [3:0] ns,
                      input logic [3:0] ew, input logic clr,
                      input logic [3:0] ens, input logic [3:0] eew,
                      input logic ef, input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    ns_in     = ns;
    ew_in     = ew;
    fault_clr = clr;
    e.tgt  = cyc + 1;
    e.name = nm;
    e.ns   = ens;
    e.ew   = eew;
    e.f    = ef;
    e.c    = ec;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ns_in = G; ew_in = R; fault_clr = 1'b0;

    step("reset0", 1, G, R, 0, R, R, 0, 2'b00);
    step("reset1", 1, G, R, 0, R, R, 0, 2'b00);

    for (int i = 0; i < 10; i++) step("pass_g_r", 0, G, R, 0, G, R, 0, 2'b00);
    for (int i = 0; i < 3; i++)  step("pass_r_l", 0, R, L, 0, R, L, 0, 2'b00);

    step("glitch_conf", 0, G, G, 0, G, G, 0, 2'b00);
    step("glitch_clean", 0, G, R, 0, G, R, 0, 2'b00);
    step("glitch_conf2", 0, G, G, 0, G, G, 0, 2'b00);
    step("glitch_clean2", 0, R, G, 0, R, G, 0, 2'b00);

    step("conf_expose", 0, G, L, 0, G, L, 0, 2'b00);
    step("conf_trip", 0, G, L, 0, R, R, 1, 2'b01);
    for (int i = 0; i < 3; i++) step("flash_on1", 0, G, L, 0, R, R, 1, 2'b01);
    for (int i = 0; i < 4; i++) step("flash_off1", 0, G, L, 0, D, D, 1, 2'b01);
    step("flash_on2", 0, G, L, 0, R, R, 1, 2'b01);
    step("clr_dirty0", 0, G, L, 1, R, R, 1, 2'b01);
    step("clr_dirty1", 0, G, L, 1, R, R, 1, 2'b01);
    step("clr_clean", 0, G, R, 1, G, R, 0, 2'b00);
    step("after_clr", 0, G, R, 0, G, R, 0, 2'b00);
    step("clr_in_monitor", 0, R, G, 1, R, G, 0, 2'b00);

    step("dark_expose", 0, R, D, 0, R, D, 0, 2'b00);
    step("dark_trip", 0, R, D, 0, R, R, 1, 2'b10);
    step("dark_clear", 0, R, R, 1, R, R, 0, 2'b00);

    step("inv_expose", 0, BAD, R, 0, BAD, R, 0, 2'b00);
    step("inv_trip", 0, BAD, R, 0, R, R, 1, 2'b11);
    step("inv_clear", 0, G, R, 1, G, R, 0, 2'b00);

    step("prio_expose", 0, BAD, G, 0, BAD, G, 0, 2'b00);
    step("prio_trip", 0, BAD, G, 0, R, R, 1, 2'b01);
    step("prio_clear", 0, R, G, 1, R, G, 0, 2'b00);

    step("mixed_dark", 0, D, R, 0, D, R, 0, 2'b00);
    step("mixed_inv_trip", 0, BAD, R, 0, R, R, 1, 2'b11);
    step("mixed_clear", 0, R, R, 1, R, R, 0, 2'b00);
    step("all_stop", 0, R, R, 0, R, R, 0, 2'b00);

    step("rst_expose", 0, G, G, 0, G, G, 0, 2'b00);
    step("rst_trip", 0, G, G, 0, R, R, 1, 2'b01);
    for (int i = 0; i < 3; i++) step("rst_flash_on", 0, G, G, 0, R, R, 1, 2'b01);
    step("rst_flash_off", 0, G, G, 0, D, D, 1, 2'b01);
    step("rst_mid_flash", 1, G, G, 1, R, R, 0, 2'b00);
    step("post_rst0", 0, G, R, 0, G, R, 0, 2'b00);
    step("post_rst1", 0, R, L, 0, R, L, 0, 2'b00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_traffic_conflict_monitor

`default_nettype wire

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Downstream safety stage between the two direction controllers (North-South and East-West) and the lamp drivers. It registers both 4-bit lamp vectors and passes them through. It trips into a latched fault when the vectors show conflicting right-of-way, a dark head or an illegal lamp pattern. While faulted it overrides both heads with flashing red until the fault is cleared by an operator or by reset.

## Interface
- FILTER_CYCLES, 2: consecutive sampled cycles a fault condition must persist before tripping; legal range ≥1.
- FLASH_HALF, 4: cycles per flash phase (red-on and dark each last this long); legal range ≥1.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ns_in  input  4  NS controller lamp vector {left, green, yellow, red}.
- ew_in  input  4  EW controller lamp vector, same encoding.
- fault_clr  input  1  operator clear request, level-sampled.
- ns_out  output  4  NS lamp-driver vector.
- ew_out  output  4  EW lamp-driver vector.
- fault  output  1  high while in a fault state.
- fault_code  output  2  00 none, 01 conflict, 10 dark, 11 invalid pattern; holds the trip cause.

## Operation
- Legal per-direction patterns are LEFT 4'b1001, GREEN 4'b0100, YELLOW 4'b0010 and RED 4'b0001. A direction is permissive when any of bits [3:1] is set.
- Conditions are evaluated each cycle on the unregistered inputs:
  - CONFLICT (01): both directions permissive.
  - DARK (10): either input is 4'b0000.
  - INVALID (11): either input is non-zero and not one of the four legal patterns.
  - Priority is CONFLICT > DARK > INVALID.
- Filter counter:
  - Increments, saturating at FILTER_CYCLES, on any cycle where some condition holds. The condition need not stay the same across cycles.
  - Clears on any clean cycle.
  - Width is $clog2(FILTER_CYCLES+1).
- States:
  - MONITOR: ns_out/ew_out <= ns_in/ew_in. When a condition holds and the counter equals FILTER_CYCLES-1, go to FLASH_ON, set fault=1 and latch fault_code from the current cycle's highest-priority condition.
  - FLASH_ON: both outputs 4'b0001. After FLASH_HALF cycles go to FLASH_OFF.
  - FLASH_OFF: both outputs 4'b0000. After FLASH_HALF cycles go to FLASH_ON.
- Flash phase counter width is $clog2(FLASH_HALF), minimum 1. It reloads to 0 on every phase change.
- fault_clr is honoured in FLASH_ON or FLASH_OFF only on a cycle where the inputs are clean.
  - On that edge: go to MONITOR, fault=0, fault_code=00, filter counter=0, and outputs take the current inputs.
  - With dirty inputs, fault_clr is ignored and flashing continues uninterrupted.
- fault_clr has no effect in MONITOR.
- Reset values: state MONITOR, ns_out=ew_out=4'b0001, fault=0, fault_code=00, both counters 0.

## Timing
- Pass-through latency in MONITOR is one cycle, all outputs registered.
- A condition present at edges k … k+FILTER_CYCLES-1 makes fault=1 and the outputs red after edge k+FILTER_CYCLES-1.
  - Offending vectors pass through for edges k … k+FILTER_CYCLES-2. This is accepted filter exposure.
- Flash period is 2·FLASH_HALF cycles. The first red-on phase starts on the trip edge and lasts exactly FLASH_HALF cycles.
- A clean cycle inside the filter window restarts the count. A new condition after a clean cycle needs a full FILTER_CYCLES.
- rst dominates fault_clr and every other input, in any state, including mid-flash.
- A controller all-stop (both heads 4'b0001) is clean and never trips.

## Structure
- Shared package traffic_pkg holds:
  - lamp constants LAMP_LEFT, LAMP_GREEN, LAMP_YELLOW, LAMP_RED, LAMP_DARK;
  - fault code constants FAULT_NONE, FAULT_CONFLICT, FAULT_DARK, FAULT_INVALID;
  - the monitor state enum.
- Sub-module lamp_checker: purely combinational classification of one 4-bit vector into permissive, dark and invalid. It is instantiated twice, once for NS and once for EW.
- The top level holds the filter counter, the state machine, the flash counter and the output registers.

## Test plan
All scenarios use defaults FILTER_CYCLES=2, FLASH_HALF=4.
- Reset, then ns_in=0100, ew_in=0001 for 10 cycles, then swap to 0001/1001 → the first output cycle is 0001/0001; afterwards outputs equal inputs delayed by one cycle; fault=0.
- ns_in=0100, ew_in=0100 for 1 cycle, then ew_in=0001 → no trip; the conflicting vector appears on the outputs for one cycle.
- ns_in=0100, ew_in=1001 held → after the 2nd edge fault=1 and fault_code=01; outputs are 0001/0001 for 4 cycles, then 0000/0000 for 4 cycles, repeating.
- ew_in=0000 for 2 cycles → code 10. Separately, ns_in=0110 for 2 cycles → code 11. ns_in=0110 with ew_in=0100 → code 01, by priority.
- Faulted, fault_clr=1 with a conflict still present → flashing continues and code is held. Then inputs 0100/0001 with fault_clr=1 → after that edge fault=0, fault_code=00 and outputs are 0100/0001.
- Faulted in FLASH_OFF, rst=1 with fault_clr=1 → after the edge outputs are 0001/0001, fault=0 and code=00; clean inputs then pass through.
